// File: rtl/snn_ni_pkg.sv
// Shared constants and types for the spiking-network interface blocks.
package snn_ni_pkg;

    localparam int unsigned NUM_SOURCES = 30;
    localparam int unsigned ADDR_W      = 12;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/spike_addr_fifo.sv
// Synchronous FIFO with a registered head word, so pop_data never comes
// combinationally from the write side. DEPTH must be a power of two
// because the pointers wrap by natural overflow.
module spike_addr_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_en  = push & ~full;
    assign pop_en   = pop & ~empty;
    assign rd_next  = rd_ptr_q + PTR_W'(1);
    assign pop_data = head_q;
    assign count    = count_q;

    // Next-state for pointers, occupancy and the registered head word.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_next;
        end

        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // The head tracks the entry at rd_ptr; when the queue would otherwise
        // be empty, the word being pushed becomes the new head directly.
        if (pop_en) begin
            if (count_q > (PTR_W+1)'(1)) begin
                head_d = mem_q[rd_next];
            end else if (push_en) begin
                head_d = push_data;
            end
        end else if (empty && push_en) begin
            head_d = push_data;
        end
    end

    // Control state with async reset and synchronous flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_en && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/spike_event_queue.sv
// Snapshots a timestep's spike vector and per-lane addresses, then pushes
// the addresses of set lanes into a FIFO one per cycle in ascending lane
// order. The FIFO head is offered on a valid/ready port.
module spike_event_queue
    import snn_ni_pkg::*;
#(
    parameter int unsigned NUM_SOURCES = snn_ni_pkg::NUM_SOURCES,
    parameter int unsigned ADDR_W      = snn_ni_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH  = 32
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          capture,
    input  logic [NUM_SOURCES-1:0]        spike_vec,
    input  logic [NUM_SOURCES*ADDR_W-1:0] src_addr_flat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W-1:0]             out_addr,
    output logic                          busy,
    output logic                          scan_done,
    output logic                          capture_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned LANE_W = $clog2(NUM_SOURCES);

    // Index of the lowest set bit; returns 0 for an all-zero vector, which
    // callers must exclude.
    function automatic logic [LANE_W-1:0] lowest_lane(input logic [NUM_SOURCES-1:0] v);
        logic [LANE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = LANE_W'(i);
            end
        end
        return idx;
    endfunction

    scan_state_e                   state_q, state_d;
    logic [NUM_SOURCES-1:0]        pending_q, pending_d;
    logic [NUM_SOURCES*ADDR_W-1:0] snap_q, snap_d;
    logic                          scan_done_q, scan_done_d;
    logic                          capture_err_q, capture_err_d;

    logic [LANE_W-1:0]             lane;
    logic [ADDR_W-1:0]             push_data;
    logic                          push;
    logic                          pop;
    logic                          fifo_full;
    logic                          fifo_empty;

    assign lane      = lowest_lane(pending_q);
    assign push_data = snap_q[lane*ADDR_W +: ADDR_W];
    assign pop       = out_valid & out_ready & ~clear;

    // Scan FSM: capture in IDLE, drain pending lanes into the FIFO in SCAN.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        snap_d        = snap_q;
        scan_done_d   = 1'b0;
        capture_err_d = capture_err_q;
        push          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    pending_d = spike_vec;
                    snap_d    = src_addr_flat;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (capture) begin
                    capture_err_d = 1'b1;
                end
                // Full is the registered occupancy, so a same-cycle pop does
                // not free a slot for this push.
                if ((pending_q != '0) && !fifo_full) begin
                    push            = 1'b1;
                    pending_d[lane] = 1'b0;
                end
                if (pending_d == '0) begin
                    state_d     = IDLE;
                    scan_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timestep clear overrides everything, including the done pulse.
        if (clear) begin
            state_d       = IDLE;
            pending_d     = '0;
            snap_d        = '0;
            scan_done_d   = 1'b0;
            capture_err_d = 1'b0;
            push          = 1'b0;
        end
    end

    // Scan state registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            snap_q        <= '0;
            scan_done_q   <= 1'b0;
            capture_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            snap_q        <= snap_d;
            scan_done_q   <= scan_done_d;
            capture_err_q <= capture_err_d;
        end
    end

    spike_addr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (out_addr),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid   = ~fifo_empty;
    assign busy        = (state_q == SCAN);
    assign scan_done   = scan_done_q;
    assign capture_err = capture_err_q;

endmodule

// File: tb/tb_spike_event_queue.sv
// Directed bench for spike_event_queue with hand-computed expectations.
module tb_spike_event_queue;

    localparam int NS = 30;
    localparam int AW = 12;

    logic              CLK;
    logic              rst_n;
    logic              clear;
    logic              capture;
    logic [NS-1:0]     spike_vec;
    logic [NS*AW-1:0]  src_addr_flat;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_addr;
    logic              busy;
    logic              scan_done;
    logic              capture_err;
    logic [5:0]        fifo_count;

    int pass_cnt;
    int total_cnt;

    spike_event_queue dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .clear         (clear),
        .capture       (capture),
        .spike_vec     (spike_vec),
        .src_addr_flat (src_addr_flat),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .busy          (busy),
        .scan_done     (scan_done),
        .capture_err   (capture_err),
        .fifo_count    (fifo_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_addrs(input logic [AW-1:0] base);
        for (int i = 0; i < NS; i++) begin
            src_addr_flat[i*AW +: AW] = base + AW'(i);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".out_valid"},   32'(out_valid),   32'd0);
        check({tag, ".out_addr"},    32'(out_addr),    32'd0);
        check({tag, ".busy"},        32'(busy),        32'd0);
        check({tag, ".scan_done"},   32'(scan_done),   32'd0);
        check({tag, ".capture_err"}, 32'(capture_err), 32'd0);
        check({tag, ".fifo_count"},  32'(fifo_count),  32'd0);
    endtask

    logic [AW-1:0] exp_q[$];
    int            idx;

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst_n         = 1'b0;
        clear         = 1'b0;
        capture       = 1'b0;
        spike_vec     = '0;
        src_addr_flat = '0;
        out_ready     = 1'b0;

        // Reset values
        #12;
        check_reset_outputs("rst");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_rst");

        // Empty capture: done in c+2, nothing queued
        capture = 1'b1;
        spike_vec = '0;
        tick();                     // c+1
        capture = 1'b0;
        check("k0.busy_c1", 32'(busy), 32'd1);
        check("k0.done_c1", 32'(scan_done), 32'd0);
        tick();                     // c+2
        check("k0.done_c2", 32'(scan_done), 32'd1);
        check("k0.busy_c2", 32'(busy), 32'd0);
        check("k0.valid_c2", 32'(out_valid), 32'd0);
        check("k0.count_c2", 32'(fifo_count), 32'd0);
        tick();
        check("k0.done_c3", 32'(scan_done), 32'd0);

        // Lanes 3, 7, 29 with addr = lane, consumer always ready
        set_addrs(12'h000);
        spike_vec = '0;
        spike_vec[3] = 1'b1;
        spike_vec[7] = 1'b1;
        spike_vec[29] = 1'b1;
        out_ready = 1'b1;
        capture = 1'b1;
        tick();                     // c+1
        capture = 1'b0;
        check("s3.busy_c1", 32'(busy), 32'd1);
        check("s3.valid_c1", 32'(out_valid), 32'd0);
        tick();                     // c+2
        check("s3.valid_c2", 32'(out_valid), 32'd1);
        check("s3.addr_c2", 32'(out_addr), 32'h003);
        tick();                     // c+3
        check("s3.addr_c3", 32'(out_addr), 32'h007);
        check("s3.done_c3", 32'(scan_done), 32'd0);
        tick();                     // c+4
        check("s3.addr_c4", 32'(out_addr), 32'h01D);
        check("s3.valid_c4", 32'(out_valid), 32'd1);
        check("s3.done_c4", 32'(scan_done), 32'd1);
        tick();                     // c+5
        check("s3.valid_c5", 32'(out_valid), 32'd0);
        check("s3.count_c5", 32'(fifo_count), 32'd0);

        // All 30 lanes, no consumer: fills to 30 without stalling
        out_ready = 1'b0;
        set_addrs(12'h200);
        spike_vec = '1;
        capture = 1'b1;
        tick();                     // c+1
        capture = 1'b0;
        for (int i = 0; i < 30; i++) tick();   // c+31
        check("all.done", 32'(scan_done), 32'd1);
        check("all.count30", 32'(fifo_count), 32'd30);
        check("all.busy", 32'(busy), 32'd0);

        // Next timestep: 3 events, only 2 fit -> stall at 32
        set_addrs(12'h300);
        spike_vec = '0;
        spike_vec[4] = 1'b1;
        spike_vec[10] = 1'b1;
        spike_vec[25] = 1'b1;
        capture = 1'b1;
        tick();                     // d+1
        capture = 1'b0;
        set_addrs(12'h700);         // snapshot must be used, not live inputs
        tick();
        tick();                     // d+3
        check("stall.count32", 32'(fifo_count), 32'd32);
        tick();
        tick();
        tick();
        check("stall.count_held", 32'(fifo_count), 32'd32);
        check("stall.busy", 32'(busy), 32'd1);
        check("stall.no_done", 32'(scan_done), 32'd0);

        for (int i = 0; i < 30; i++) exp_q.push_back(12'h200 + 12'(i));
        exp_q.push_back(12'h304);
        exp_q.push_back(12'h30A);
        exp_q.push_back(12'h319);

        out_ready = 1'b1;
        idx = 0;
        for (int n = 0; n < 100 && idx < 33; n++) begin
            if (out_valid) begin
                check($sformatf("drain.addr%0d", idx), 32'(out_addr), 32'(exp_q[idx]));
                idx++;
            end
            tick();
        end
        check("drain.total", 32'(idx), 32'd33);
        check("drain.valid_end", 32'(out_valid), 32'd0);
        check("drain.count_end", 32'(fifo_count), 32'd0);
        check("drain.busy_end", 32'(busy), 32'd0);

        // Capture during SCAN sets capture_err and is ignored
        out_ready = 1'b0;
        set_addrs(12'h400);
        spike_vec = 30'h1F;
        capture = 1'b1;
        tick();                     // c+1
        spike_vec = '0;
        spike_vec[10] = 1'b1;
        tick();                     // c+2
        capture = 1'b0;
        check("err.set", 32'(capture_err), 32'd1);
        tick();
        tick();
        tick();
        tick();                     // c+6
        check("err.done", 32'(scan_done), 32'd1);
        check("err.count5", 32'(fifo_count), 32'd5);
        tick();
        tick();
        check("err.count_held", 32'(fifo_count), 32'd5);
        check("err.sticky", 32'(capture_err), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("err.cleared", 32'(capture_err), 32'd0);
        check("err.clr_count", 32'(fifo_count), 32'd0);
        check("err.clr_valid", 32'(out_valid), 32'd0);

        // Clear mid-scan with 10 lanes still pending
        set_addrs(12'h100);
        spike_vec = 30'hFFF;
        capture = 1'b1;
        tick();                     // c+1
        capture = 1'b0;
        tick();
        tick();                     // c+3
        check("mclr.count2", 32'(fifo_count), 32'd2);
        clear = 1'b1;
        tick();                     // c+4
        clear = 1'b0;
        check("mclr.busy", 32'(busy), 32'd0);
        check("mclr.count", 32'(fifo_count), 32'd0);
        check("mclr.valid", 32'(out_valid), 32'd0);
        check("mclr.no_done", 32'(scan_done), 32'd0);
        tick();
        check("mclr.no_done2", 32'(scan_done), 32'd0);
        check("mclr.count2b", 32'(fifo_count), 32'd0);

        // Async reset mid-scan, then a fresh capture
        set_addrs(12'h500);
        spike_vec = 30'h3F;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        tick();
        check("mrst.count1", 32'(fifo_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mrst");
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst.idle", 32'(busy), 32'd0);

        set_addrs(12'h600);
        spike_vec = 30'h6;
        out_ready = 1'b1;
        capture = 1'b1;
        tick();                     // c+1
        capture = 1'b0;
        check("fresh.busy", 32'(busy), 32'd1);
        tick();                     // c+2
        check("fresh.addr1", 32'(out_addr), 32'h601);
        check("fresh.valid1", 32'(out_valid), 32'd1);
        tick();                     // c+3
        check("fresh.addr2", 32'(out_addr), 32'h602);
        check("fresh.done", 32'(scan_done), 32'd1);
        tick();
        check("fresh.empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spike_event_queue.md
# spike_event_queue

Serialises the per-timestep spike output of the 30-lane network interface into a single ordered stream of 12-bit source addresses for the downstream synaptic accumulator. On a capture strobe it snapshots the spike vector and the 30 source-address buses, pushes one address per cycle into an internal FIFO in ascending lane order, and presents the FIFO head on a valid/ready port. It sits between the network interface and the accumulator/weight-lookup stage.

## Interface
- NUM_SOURCES, 30, number of spike lanes
- ADDR_W, 12, source-address width
- FIFO_DEPTH, 32, queue entries; must be a power of two and at least NUM_SOURCES
- CLK  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- clear  in  1  synchronous timestep clear; flushes all state
- capture  in  1  one-cycle strobe; snapshot inputs
- spike_vec  in  NUM_SOURCES  per-lane spike flags
- src_addr_flat  in  NUM_SOURCES*ADDR_W  lane i address at bits [i*ADDR_W +: ADDR_W]
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head
- out_addr  out  ADDR_W  FIFO head address
- busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse when scan completes
- capture_err  out  1  sticky; capture arrived while busy
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- States: IDLE, SCAN. Reset and clear force IDLE.
- IDLE + capture: latch pending <= spike_vec and addr snapshot <= src_addr_flat; go SCAN; busy=1.
- SCAN, each edge: if pending != 0 and FIFO not full, push snapshot address of lowest set lane, clear that pending bit. If pending is zero after this edge's update, go IDLE and pulse scan_done.
- FIFO full: scan stalls (no push, pending held); no events are dropped.
- Full test uses registered count; a pop in the same cycle does not enable a push.
- Pop when out_valid && out_ready. Pop on empty is ignored.
- capture while in SCAN is ignored and sets capture_err; cleared only by clear or reset.
- clear has priority over capture, push and pop: FIFO emptied, pending=0, state IDLE, scan_done not pulsed, capture_err=0.
- Pointers wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH.
- Order: ascending lane index within a timestep; successive timesteps FIFO order.

## Timing
- Reset values: out_valid=0, out_addr=0, busy=0, scan_done=0, capture_err=0, fifo_count=0; pending, snapshot and pointers zero.
- capture high in cycle c: busy high from c+1; first push at end of c+1; out_valid high from c+2 when ≥1 spike.
- k spikes, no stall: scan_done high in cycle c+k+1; k=0: scan_done high in cycle c+2 with no push.
- Each stall cycle delays scan_done by one cycle.
- out_addr is registered FIFO read data, valid whenever out_valid=1; no combinational path from spike_vec to out_addr.
- Throughput: one push and one pop per cycle.
- rst_n assertion mid-scan: immediate return to reset values; the snapshot is discarded.

## Structure
- Shared package snn_ni_pkg: ADDR_W, NUM_SOURCES, state enum {IDLE, SCAN}. The network interface also uses this package.
- Sub-module spike_addr_fifo: synchronous FIFO, params DEPTH/WIDTH; push, pop, full, empty, count; async active-low reset.
- Lowest-set-lane priority encoder lives inside spike_event_queue as a function.

## Test plan
- Reset, then capture with spike_vec=0 -> scan_done high in cycle c+2, out_valid stays 0, fifo_count=0.
- spike_vec bits 3, 7, 29 set, addresses 0x003/0x007/0x01D, out_ready=1 -> out_addr 0x003, 0x007, 0x01D on consecutive valid cycles; scan_done in cycle c+4.
- All 30 lanes set, out_ready=0, FIFO_DEPTH=32 -> fifo_count reaches 30 with no stall; then 2 more captures after scan_done -> scan stalls at count=32, no loss, drains in order when out_ready=1.
- capture asserted again during SCAN -> capture_err=1, second snapshot ignored; clear -> capture_err=0, FIFO empty next cycle.
- clear asserted mid-scan with 10 pending lanes -> IDLE next cycle, fifo_count=0, no scan_done pulse.
- rst_n low for one cycle mid-scan -> all outputs at reset values immediately; a fresh capture afterwards works normally.
